cpu_core: RTL and testbench
===========================

Name: cpu_core

Overview:
Parametrised successor of the skeleton CPU: a multi-cycle fetch/decode/execute core with a general-purpose register file, a 16-bit fixed instruction format, and ALU, load/store, branch and halt instructions.
- Sits between a synchronous instruction ROM and a synchronous data RAM, both with 1-cycle read latency.
- Its port set is a superset of the previous CPU top.

Parameters:
g_ROM_WIDTH, 16, instruction width; must be 16.
g_ROM_ADDR, 9, ROM address and PC width.
g_RAM_WIDTH, 8, RAM word width; equals the GPR data width.
g_RAM_ADDR, 9, RAM address width.
g_NUM_GPR, 16, number of GPRs (2..16); a register index >= g_NUM_GPR reads 0 and writes are dropped.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous, active-low reset.
o_rom_en  out  1  ROM read strobe.
o_rom_addr  out  g_ROM_ADDR  ROM address (= PC).
i_rom_data  in  g_ROM_WIDTH  instruction, valid the cycle after o_rom_en.
o_ram_en  out  1  RAM enable.
o_ram_we  out  1  RAM write strobe.
o_ram_re  out  1  RAM read strobe.
o_ram_addr  out  g_RAM_ADDR  RAM address.
o_ram_data  out  g_RAM_WIDTH  RAM write data.
i_ram_data  in  g_RAM_WIDTH  RAM read data, valid the cycle after o_ram_re.
o_halted  out  1  high while in HALT.

Behaviour:
- Instruction fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm8=[7:0].
- imm8 is zero-extended or truncated to the destination width. RAM address = gpr[rs] zero-extended or truncated to g_RAM_ADDR.
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd=imm8.
  - 2 ADD: rd=rs+rt; C=carry-out.
  - 3 SUB: rd=rs-rt; C=borrow.
  - 4 AND, 5 OR, 6 XOR.
  - 7 SHL: rd=rs<<1; C=msb shifted out.
  - 8 LD: rd=RAM[gpr[rs]].
  - 9 ST: RAM[gpr[rs]]=gpr[rd].
  - A JMP: pc=imm8.
  - B BZ: if gpr[rd]==0, pc=imm8.
  - C BNZ: if gpr[rd]!=0, pc=imm8.
  - D ADC: rd=rs+rt+C; C=carry-out.
  - E: reserved, executes as NOP.
  - F HALT.
- Arithmetic is modulo 2^g_RAM_WIDTH. C is updated only by ADD, SUB, SHL and ADC.
- States: FETCH -> DECODE -> EXEC -> (MEM if LD) -> FETCH; HALT is absorbing.
  - FETCH: o_rom_en=1, o_rom_addr=pc.
  - DECODE: latch i_rom_data into the IR; pc<=pc+1, wrapping at 2^g_ROM_ADDR.
  - EXEC:
    - ALU ops and LDI write rd at the end of EXEC.
    - Jump/branch loads pc, overriding the increment.
    - ST: o_ram_en=o_ram_we=1 for exactly this cycle, with o_ram_addr/o_ram_data valid.
    - LD: o_ram_en=o_ram_re=1 for exactly this cycle; next state MEM.
    - HALT: next state HALT.
  - MEM: i_ram_data is written to rd at the end of the cycle.
  - HALT: all strobes 0, o_halted=1; exit only via reset.
- Latency: 3 cycles per instruction, 4 for LD.
- Strobes are decoded from the state and are single-cycle. o_ram_we and o_ram_re are never high together.
- Reset (i_rst=0), taking effect immediately:
  - pc=0, all GPRs=0, C=0, IR=0, state=FETCH.
  - All strobes and o_halted forced 0, o_rom_addr=0, o_ram_addr=0, o_ram_data=0.
  - Reset mid-LD discards the pending load.
  - After release, the first FETCH occurs on the first clock.
- Same-instruction read/write (e.g. ADD r1,r1,r1): operands are read before writeback.

Optional Feature:
CPU_DBG_EN:
- Defined: adds i_dbg_sel (in, 4), o_dbg_gpr (out, g_RAM_WIDTH) and o_dbg_pc (out, g_ROM_ADDR).
  - o_dbg_gpr is a combinational read of gpr[i_dbg_sel], 0 if the index is out of range.
  - o_dbg_pc = pc.
  - These ports have no effect on execution.
- Undefined: the ports and their logic are absent.

Decomposition:
- cpu_pkg holds:
  - opcode localparams OP_NOP..OP_HALT;
  - state encoding S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT;
  - instruction field bit positions.
- One sub-module, cpu_alu: combinational op/a/b/cin in, result/cout out, parametrised by g_RAM_WIDTH.

Test Plan:
- LDI r1,0xF0; LDI r2,0x20; ADD r3,r1,r2 -> r3=0x10, C=1; ADC r4,r0,r0 -> r4=0x01; each ALU op 3 cycles.
- LDI r1,0x05; LDI r2,0xAA; ST r2,[r1]; LD r3,[r1] -> single-cycle we pulse with addr=5, data=0xAA; re pulse with addr=5; r3=0xAA; LD takes 4 cycles.
- LDI r1,0; BZ r1,0x10 -> next fetch addr=0x10; with r1=1 -> next fetch addr = branch addr+1; BNZ mirrored.
- HALT -> o_halted=1 and no further rom_en over 20 cycles; a reset pulse restarts fetch at addr 0.
- Assert i_rst during the MEM state of an LD -> strobes drop immediately, rd unchanged (0), pc=0 after release.
- Place NOP at 2^g_ROM_ADDR-1 -> PC wraps to 0; reserved opcode E behaves as NOP; with g_NUM_GPR=4, a write to r5 is dropped and r5 reads 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_pkg : opcodes, FSM state encoding and instruction field positions |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_BNZ  = 4'hC;
    localparam logic [3:0] OP_ADC  = 4'hD;
    localparam logic [3:0] OP_RSV  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam int F_OP_HI  = 15;
    localparam int F_OP_LO  = 12;
    localparam int F_RD_HI  = 11;
    localparam int F_RD_LO  = 8;
    localparam int F_RS_HI  = 7;
    localparam int F_RS_LO  = 4;
    localparam int F_RT_HI  = 3;
    localparam int F_RT_LO  = 0;
    localparam int F_IMM_HI = 7;
    localparam int F_IMM_LO = 0;

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_alu : combinational ALU; carry out doubles as borrow for SUB      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int g_RAM_WIDTH = 8
) (
    input  logic [3:0]             i_op,
    input  logic [g_RAM_WIDTH-1:0] i_a,
    input  logic [g_RAM_WIDTH-1:0] i_b,
    input  logic                   i_cin,
    output logic [g_RAM_WIDTH-1:0] o_result,
    output logic                   o_cout
);

    logic [g_RAM_WIDTH:0] w_wide;

    always_comb begin
        w_wide = '0;
        case (i_op)
            OP_ADD:  w_wide = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:  w_wide = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:  w_wide = {1'b0, i_a & i_b};
            OP_OR:   w_wide = {1'b0, i_a | i_b};
            OP_XOR:  w_wide = {1'b0, i_a ^ i_b};
            OP_SHL:  w_wide = {i_a, 1'b0};
            OP_ADC:  w_wide = {1'b0, i_a} + {1'b0, i_b} + {{g_RAM_WIDTH{1'b0}}, i_cin};
            default: w_wide = '0;
        endcase
    end

    assign o_result = w_wide[g_RAM_WIDTH-1:0];
    assign o_cout   = w_wide[g_RAM_WIDTH];

endmodule
`default_nettype wire

// File: rtl/cpu_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_core : multi-cycle fetch/decode/execute core, 16-bit instructions |
// | Optional debug ports enabled by CPU_DBG_EN.  Revision: 1.0            |
// +-----------------------------------------------------------------------+
module cpu_core
    import cpu_pkg::*;
#(
    parameter int g_ROM_WIDTH = 16,
    parameter int g_ROM_ADDR  = 9,
    parameter int g_RAM_WIDTH = 8,
    parameter int g_RAM_ADDR  = 9,
    parameter int g_NUM_GPR   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic                   o_rom_en,
    output logic [g_ROM_ADDR-1:0]  o_rom_addr,
    input  logic [g_ROM_WIDTH-1:0] i_rom_data,
    output logic                   o_ram_en,
    output logic                   o_ram_we,
    output logic                   o_ram_re,
    output logic [g_RAM_ADDR-1:0]  o_ram_addr,
    output logic [g_RAM_WIDTH-1:0] o_ram_data,
    input  logic [g_RAM_WIDTH-1:0] i_ram_data,
    output logic                   o_halted
`ifdef CPU_DBG_EN
    ,
    input  logic [3:0]             i_dbg_sel,
    output logic [g_RAM_WIDTH-1:0] o_dbg_gpr,
    output logic [g_ROM_ADDR-1:0]  o_dbg_pc
`endif
);

    state_t                 state_q, state_d;
    logic [g_ROM_ADDR-1:0]  pc_q, pc_d;
    logic [g_ROM_WIDTH-1:0] ir_q, ir_d;
    logic                   carry_q, carry_d;
    logic [g_RAM_WIDTH-1:0] gpr_q [g_NUM_GPR];
    logic [g_RAM_WIDTH-1:0] gpr_d [g_NUM_GPR];

    logic [3:0]             w_op, w_rd, w_rs, w_rt;
    logic [g_RAM_WIDTH-1:0] w_rd_val, w_rs_val, w_rt_val, w_imm;
    logic [g_ROM_ADDR-1:0]  w_target;
    logic [g_RAM_WIDTH-1:0] w_alu_res, w_wr_val;
    logic                   w_alu_cout, w_wr_en, w_exec, w_st, w_ld;

    assign w_op     = ir_q[F_OP_HI:F_OP_LO];
    assign w_rd     = ir_q[F_RD_HI:F_RD_LO];
    assign w_rs     = ir_q[F_RS_HI:F_RS_LO];
    assign w_rt     = ir_q[F_RT_HI:F_RT_LO];
    assign w_imm    = g_RAM_WIDTH'(ir_q[F_IMM_HI:F_IMM_LO]);
    assign w_target = g_ROM_ADDR'(ir_q[F_IMM_HI:F_IMM_LO]);

    // Indices beyond the implemented register count read as zero.
    always_comb begin
        w_rd_val = '0;
        w_rs_val = '0;
        w_rt_val = '0;
        for (int i = 0; i < g_NUM_GPR; i++) begin
            if (w_rd == 4'(i)) w_rd_val = gpr_q[i];
            if (w_rs == 4'(i)) w_rs_val = gpr_q[i];
            if (w_rt == 4'(i)) w_rt_val = gpr_q[i];
        end
    end

    cpu_alu #(
        .g_RAM_WIDTH(g_RAM_WIDTH)
    ) u_alu (
        .i_op    (w_op),
        .i_a     (w_rs_val),
        .i_b     (w_rt_val),
        .i_cin   (carry_q),
        .o_result(w_alu_res),
        .o_cout  (w_alu_cout)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        gpr_d   = gpr_q;
        w_wr_en  = 1'b0;
        w_wr_val = '0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = i_rom_data;
                pc_d    = pc_q + g_ROM_ADDR'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (w_op)
                    OP_LDI: begin
                        w_wr_en  = 1'b1;
                        w_wr_val = w_imm;
                    end
                    OP_ADD, OP_SUB, OP_SHL, OP_ADC: begin
                        w_wr_en  = 1'b1;
                        w_wr_val = w_alu_res;
                        carry_d  = w_alu_cout;
                    end
                    OP_AND, OP_OR, OP_XOR: begin
                        w_wr_en  = 1'b1;
                        w_wr_val = w_alu_res;
                    end
                    OP_LD:   state_d = S_MEM;
                    OP_JMP:  pc_d = w_target;
                    OP_BZ:   if (w_rd_val == '0) pc_d = w_target;
                    OP_BNZ:  if (w_rd_val != '0) pc_d = w_target;
                    OP_HALT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_MEM: begin
                w_wr_en  = 1'b1;
                w_wr_val = i_ram_data;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        for (int i = 0; i < g_NUM_GPR; i++) begin
            if (w_wr_en && (w_rd == 4'(i))) gpr_d[i] = w_wr_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            carry_q <= 1'b0;
            for (int i = 0; i < g_NUM_GPR; i++) gpr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            gpr_q   <= gpr_d;
        end
    end

    // Outputs are gated by the reset input so they drop in the same cycle it asserts.
    assign w_exec = i_rst && (state_q == S_EXEC);
    assign w_st   = w_exec && (w_op == OP_ST);
    assign w_ld   = w_exec && (w_op == OP_LD);

    assign o_rom_en   = i_rst && (state_q == S_FETCH);
    assign o_rom_addr = i_rst ? pc_q : '0;
    assign o_ram_we   = w_st;
    assign o_ram_re   = w_ld;
    assign o_ram_en   = w_st || w_ld;
    assign o_ram_addr = (w_st || w_ld) ? g_RAM_ADDR'(w_rs_val) : '0;
    assign o_ram_data = w_st ? w_rd_val : '0;
    assign o_halted   = i_rst && (state_q == S_HALT);

`ifdef CPU_DBG_EN
    always_comb begin
        o_dbg_gpr = '0;
        for (int i = 0; i < g_NUM_GPR; i++) begin
            if (i_dbg_sel == 4'(i)) o_dbg_gpr = gpr_q[i];
        end
    end
    assign o_dbg_pc = pc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cpu_core : ROM/RAM models, ISA-level reference model, bus checks   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_cpu_core;

    localparam int NGPR = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rom_en, ram_en, ram_we, ram_re, halted;
    logic [8:0] rom_addr, ram_addr;
    logic [15:0] rom_data = '0;
    logic [7:0] ram_wdata, ram_rdata = '0;
`ifdef CPU_DBG_EN
    logic [3:0] dbg_sel = '0;
    logic [7:0] dbg_gpr;
    logic [8:0] dbg_pc;
`endif

    always #5 clk = ~clk;

    cpu_core #(
        .g_ROM_WIDTH(16), .g_ROM_ADDR(9), .g_RAM_WIDTH(8), .g_RAM_ADDR(9), .g_NUM_GPR(NGPR)
    ) dut (
        .i_clk(clk), .i_rst(rst_n),
        .o_rom_en(rom_en), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_re(ram_re),
        .o_ram_addr(ram_addr), .o_ram_data(ram_wdata), .i_ram_data(ram_rdata),
        .o_halted(halted)
`ifdef CPU_DBG_EN
        , .i_dbg_sel(dbg_sel), .o_dbg_gpr(dbg_gpr), .o_dbg_pc(dbg_pc)
`endif
    );

    logic [15:0] rom  [512];
    logic [7:0]  ram  [512];
    logic [7:0]  mram [512];

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
        if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_en && ram_re) ram_rdata <= ram[ram_addr];
    end

    // Bus monitor
    bit mon_on = 1'b0;
    int cyc, bad_strobe;
    int act_fa[$], act_fc[$], act_sa[$], act_sd[$], act_la[$];

    always @(negedge clk) begin
        if (mon_on) begin
            cyc++;
            if (rom_en) begin
                act_fa.push_back(int'(rom_addr));
                act_fc.push_back(cyc);
            end
            if (ram_we) begin
                act_sa.push_back(int'(ram_addr));
                act_sd.push_back(int'(ram_wdata));
            end
            if (ram_re) act_la.push_back(int'(ram_addr));
            if ((ram_we && ram_re) || (ram_en != (ram_we || ram_re))) bad_strobe++;
        end
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ISA-level reference model
    int exp_fa[$], exp_gap[$], exp_sa[$], exp_sd[$], exp_la[$];

    task automatic model_run();
        int g[16];
        int pc, npc, c, lat, op, rd, rs, rt, imm, a, b, dv, wv, s;
        logic [15:0] ins;
        bit done;
        exp_fa.delete(); exp_gap.delete(); exp_sa.delete(); exp_sd.delete(); exp_la.delete();
        for (int i = 0; i < 16; i++) g[i] = 0;
        pc = 0; c = 0; lat = 0; done = 1'b0;
        for (int step = 0; step < 4000 && !done; step++) begin
            ins = rom[pc];
            op = int'(ins[15:12]); rd = int'(ins[11:8]); rs = int'(ins[7:4]);
            rt = int'(ins[3:0]);   imm = int'(ins[7:0]);
            exp_fa.push_back(pc);
            exp_gap.push_back(lat);
            lat = 3;
            npc = (pc + 1) % 512;
            a  = (rs < NGPR) ? g[rs] : 0;
            b  = (rt < NGPR) ? g[rt] : 0;
            dv = (rd < NGPR) ? g[rd] : 0;
            wv = -1;
            case (op)
                1:  wv = imm;
                2:  begin s = a + b;     wv = s % 256; c = s / 256; end
                3:  begin wv = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
                4:  wv = a & b;
                5:  wv = a | b;
                6:  wv = a ^ b;
                7:  begin s = 2 * a;     wv = s % 256; c = s / 256; end
                8:  begin exp_la.push_back(a); wv = int'(mram[a]); lat = 4; end
                9:  begin exp_sa.push_back(a); exp_sd.push_back(dv); mram[a] = 8'(dv); end
                10: npc = imm;
                11: if (dv == 0) npc = imm;
                12: if (dv != 0) npc = imm;
                13: begin s = a + b + c; wv = s % 256; c = s / 256; end
                15: done = 1'b1;
                default: ;
            endcase
            if (wv >= 0 && rd < NGPR) g[rd] = wv;
            pc = npc;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
    endtask

    task automatic hold_reset();
        @(posedge clk); #2;
        mon_on = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        for (int i = 0; i < 512; i++) mram[i] = ram[i];
        model_run();
        @(posedge clk); #2;
        act_fa.delete(); act_fc.delete(); act_sa.delete(); act_sd.delete(); act_la.delete();
        cyc = 0; bad_strobe = 0;
        rst_n  = 1'b1;
        mon_on = 1'b1;
    endtask

    task automatic compare(input string nm);
        int f0;
        check({nm, ".nfetch"}, 32'(act_fa.size()), 32'(exp_fa.size()));
        if (act_fc.size() > 0) check({nm, ".first_cyc"}, 32'(act_fc[0]), 32'd1);
        for (int i = 0; i < exp_fa.size() && i < act_fa.size(); i++) begin
            f0 = n_checks - n_pass;
            check({nm, ".fetch_addr"}, 32'(act_fa[i]), 32'(exp_fa[i]));
            if (i > 0) check({nm, ".gap"}, 32'(act_fc[i] - act_fc[i-1]), 32'(exp_gap[i]));
            if (n_checks - n_pass != f0) break;
        end
        check({nm, ".nstore"}, 32'(act_sa.size()), 32'(exp_sa.size()));
        for (int i = 0; i < exp_sa.size() && i < act_sa.size(); i++) begin
            f0 = n_checks - n_pass;
            check({nm, ".st_addr"}, 32'(act_sa[i]), 32'(exp_sa[i]));
            check({nm, ".st_data"}, 32'(act_sd[i]), 32'(exp_sd[i]));
            if (n_checks - n_pass != f0) break;
        end
        check({nm, ".nload"}, 32'(act_la.size()), 32'(exp_la.size()));
        for (int i = 0; i < exp_la.size() && i < act_la.size(); i++) begin
            f0 = n_checks - n_pass;
            check({nm, ".ld_addr"}, 32'(act_la[i]), 32'(exp_la[i]));
            if (n_checks - n_pass != f0) break;
        end
        check({nm, ".strobe_rules"}, 32'(bad_strobe), 32'd0);
    endtask

    task automatic finish_run(input string nm, input int budget);
        for (int k = 0; k < budget && !halted; k++) @(negedge clk);
        check({nm, ".halted"}, 32'(halted), 32'd1);
        repeat (20) @(negedge clk);
        check({nm, ".still_halted"}, 32'(halted), 32'd1);
        compare(nm);
    endtask

    task automatic run_prog(input string nm, input int budget);
        hold_reset();
        release_reset();
        finish_run(nm, budget);
    endtask

    task automatic gen_random(input int n);
        int op, rd, rs, rt;
        clear_rom();
        for (int p = 0; p < n; p++) begin
            op = int'($urandom_range(14, 0));
            rd = int'($urandom_range(9, 0));
            rs = int'($urandom_range(9, 0));
            rt = int'($urandom_range(9, 0));
            if (op >= 10 && op <= 12)
                rom[p] = {4'(op), 4'(rd), 8'($urandom_range(n, p + 1))};
            else if (op == 1)
                rom[p] = {4'h1, 4'(rd), 8'($urandom)};
            else
                rom[p] = {4'(op), 4'(rd), 4'(rs), 4'(rt)};
        end
        // Epilogue exposes carry via ADC and dumps every register to RAM.
        rom[n]     = 16'h1700;
        rom[n + 1] = 16'hD777;
        for (int r = 0; r < 16; r++) rom[n + 2 + r] = {4'h9, 4'(r), 8'h00};
        rom[n + 18] = 16'hF000;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
        #3;
        check("reset.strobes", 32'({rom_en, ram_en, ram_we, ram_re, halted}), 32'd0);
        check("reset.addrs", 32'({rom_addr, ram_addr, ram_wdata}), 32'd0);

        // ALU + carry chain
        clear_rom();
        rom[0] = 16'h11F0; rom[1] = 16'h1220; rom[2] = 16'h2312; rom[3] = 16'hD400;
        rom[4] = 16'h1540; rom[5] = 16'h9350; rom[6] = 16'h1641; rom[7] = 16'h9460;
        rom[8] = 16'hF000;
        run_prog("alu", 200);
        check("alu.r3", 32'(act_sd[0]), 32'h10);
        check("alu.r3_addr", 32'(act_sa[0]), 32'h40);
        check("alu.adc_r4", 32'(act_sd[1]), 32'h01);
        check("alu.add_cycles", 32'(act_fc[3] - act_fc[2]), 32'd3);

        // store then load
        clear_rom();
        rom[0] = 16'h1105; rom[1] = 16'h12AA; rom[2] = 16'h9210; rom[3] = 16'h8310;
        rom[4] = 16'h1406; rom[5] = 16'h9340; rom[6] = 16'hF000;
        run_prog("ldst", 200);
        check("ldst.st_addr", 32'(act_sa[0]), 32'h05);
        check("ldst.st_data", 32'(act_sd[0]), 32'hAA);
        check("ldst.ld_addr", 32'(act_la[0]), 32'h05);
        check("ldst.r3", 32'(act_sd[1]), 32'hAA);
        check("ldst.ld_cycles", 32'(act_fc[4] - act_fc[3]), 32'd4);

        // branches
        clear_rom();
        rom[0] = 16'h1100; rom[1] = 16'hB110; rom[16'h10] = 16'h1101; rom[16'h11] = 16'hB120;
        rom[16'h12] = 16'hC130; rom[16'h30] = 16'h1200; rom[16'h31] = 16'hC240;
        rom[16'h32] = 16'hF000;
        run_prog("branch", 200);
        check("branch.bz_taken", 32'(act_fa[2]), 32'h10);
        check("branch.bz_not", 32'(act_fa[4]), 32'h12);
        check("branch.bnz_taken", 32'(act_fa[5]), 32'h30);
        check("branch.bnz_not", 32'(act_fa[7]), 32'h32);

        // out-of-range register and reserved opcode
        clear_rom();
        rom[0] = 16'h1955; rom[1] = 16'h1110; rom[2] = 16'h9910; rom[3] = 16'h2291;
        rom[4] = 16'h9210; rom[5] = 16'hE123; rom[6] = 16'hF000;
        run_prog("gprdrop", 200);
        check("gprdrop.restart_addr", 32'(act_fa[0]), 32'd0);
        check("gprdrop.r9", 32'(act_sd[0]), 32'h00);
        check("gprdrop.add", 32'(act_sd[1]), 32'h10);

        // reset during the MEM cycle of a load
        clear_rom();
        rom[0] = 16'h9320; rom[1] = 16'h1105; rom[2] = 16'h8310; rom[3] = 16'h9320;
        rom[4] = 16'hF000;
        ram[5] = 8'hAB;
        hold_reset();
        release_reset();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ram_re) break;
        end
        check("midld.saw_re", 32'(ram_re), 32'd1);
        @(posedge clk); #1;
        mon_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midld.strobes", 32'({rom_en, ram_en, ram_we, ram_re, halted}), 32'd0);
        check("midld.addrs", 32'({rom_addr, ram_addr, ram_wdata}), 32'd0);
        release_reset();
        finish_run("midld", 200);
        check("midld.pc0", 32'(act_fa[0]), 32'd0);
        check("midld.rd_cleared", 32'(act_sd[0]), 32'h00);
        check("midld.reload", 32'(act_sd[1]), 32'hAB);

        // PC wrap from the top of ROM
        clear_rom();
        rom[0] = 16'hC105; rom[1] = 16'h1101; rom[2] = 16'hA0FF; rom[5] = 16'hF000;
        rom[9'h1FE] = 16'hE123;
        run_prog("wrap", 3000);
        check("wrap.top", 32'(act_fa[259]), 32'h1FF);
        check("wrap.zero", 32'(act_fa[260]), 32'h000);
        check("wrap.target", 32'(act_fa[261]), 32'h005);

        // randomized programs
        for (int t = 0; t < 6; t++) begin
            gen_random(30);
            run_prog("random", 600);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
